// File: rtl/mac_sched.sv
// Round-robin scheduler sharing one bit-serial mac among NREQ requesters.
// Latency: GNT to RES_VALID = 1 + CW + mac latency + 1 cycles; one job in flight at a time.
// Backpressure: no grant while BUSY or while the mac is not READY; REQ must be held until GNT.
module mac_sched #(
  parameter int NREQ = 2,
  parameter int DW   = 4,
  parameter int CW   = 2*DW,
  parameter int TMO  = 4*CW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] a_in,
  input  logic [NREQ*DW-1:0] b_in,
  input  logic [NREQ*CW-1:0] c_in,
  output logic [NREQ-1:0]    gnt,
  output logic [CW-1:0]      res,
  output logic [NREQ-1:0]    res_valid,
  output logic               err,
  output logic               busy,
  output logic               mac_start,
  output logic               mac_a,
  output logic               mac_b,
  output logic               mac_c,
  input  logic               mac_ready,
  input  logic               mac_o,
  input  logic               mac_o_valid,
  input  logic               mac_end
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int KW = $clog2(CW);
  localparam int NW = $clog2(CW + 1);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, COLLECT, DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr;      // first requester considered in the next arbitration
  logic [PW-1:0]   win;      // requester owning the current job
  logic [PW-1:0]   win_n;
  logic [PW-1:0]   idx;
  logic            win_hit;
  logic [CW-1:0]   a_l, b_l, c_l;
  logic [CW-1:0]   cap;      // deserialised result, filled LSB-first
  logic [KW-1:0]   k;        // serial bit index while sending
  logic [NW-1:0]   cnt;      // captured bits, saturating at CW
  logic [TW-1:0]   tmr;      // cycles since the mac was started
  logic            tmo_hit;
  logic            cap_en;

  // Round-robin pick: first requester at or after ptr, wrapping.
  always_comb begin
    win_n   = '0;
    win_hit = 1'b0;
    idx     = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_hit && req[idx]) begin
        win_hit = 1'b1;
        win_n   = idx;
      end
      idx = (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and all outputs; serial lines are quiet outside SEND.
  always_comb begin
    state_n   = state;
    gnt       = '0;
    res       = '0;
    res_valid = '0;
    err       = 1'b0;
    busy      = 1'b0;
    mac_start = 1'b0;
    mac_a     = 1'b0;
    mac_b     = 1'b0;
    mac_c     = 1'b0;
    tmo_hit   = 1'b0;
    cap_en    = 1'b0;
    case (state)
      IDLE: begin
        if (win_hit && mac_ready) state_n = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        gnt[win] = 1'b1;
        state_n  = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        mac_start = (k == '0);
        mac_a     = a_l[k];
        mac_b     = b_l[k];
        mac_c     = c_l[k];
        // Bit 0 cycle is the start itself; the mac cannot answer before it.
        cap_en    = (k != '0) && mac_o_valid;
        if ((k != '0) && mac_end) begin
          state_n = DONE;
        end else if (tmr == TW'(TMO)) begin
          tmo_hit = 1'b1;
          err     = 1'b1;
          state_n = IDLE;
        end else if (k == KW'(CW - 1)) begin
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        busy   = 1'b1;
        cap_en = mac_o_valid;
        if (mac_end) begin
          state_n = DONE;
        end else if (tmr == TW'(TMO)) begin
          tmo_hit = 1'b1;
          err     = 1'b1;
          state_n = IDLE;
        end
      end
      DONE: begin
        busy = 1'b1;
        if (cnt == NW'(CW)) begin
          res            = cap;
          res_valid[win] = 1'b1;
        end else begin
          err = 1'b1;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, serial index, capture shifter, timeout counter and RR pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      win <= '0;
      a_l <= '0;
      b_l <= '0;
      c_l <= '0;
      cap <= '0;
      k   <= '0;
      cnt <= '0;
      tmr <= '0;
    end else begin
      if (state == IDLE && state_n == LOAD) win <= win_n;
      if (state == LOAD) begin
        // A and B are zero-extended so the upper serial bits come out as 0.
        a_l <= CW'(a_in[int'(win)*DW +: DW]);
        b_l <= CW'(b_in[int'(win)*DW +: DW]);
        c_l <= c_in[int'(win)*CW +: CW];
        cap <= '0;
        k   <= '0;
        cnt <= '0;
        tmr <= '0;
      end
      if (state == SEND || state == COLLECT) tmr <= tmr + TW'(1);
      if (state == SEND) k <= k + KW'(1);
      if (cap_en) begin
        cap <= {mac_o, cap[CW-1:1]};
        if (cnt != NW'(CW)) cnt <= cnt + NW'(1);
      end
      // Pointer moves past the winner whether the job succeeded or failed.
      if (state == DONE || tmo_hit) ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: tb/tb_mac_sched.sv
// Bench for mac_sched: behavioural mac, requester drivers and a transaction-level reference.
// The reference tracks one job at a time and derives every output from the arbitration rules.
// Directed cases pin literal results; a random phase then exercises contention and faults.
module tb_mac_sched;
  localparam int NREQ = 2, DW = 4, CW = 8, TMO = 32;
  localparam int M_NORM = 0, M_SHORT = 1, M_NOEND = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] a_in = '0, b_in = '0;
  logic [NREQ*CW-1:0] c_in = '0;
  logic [NREQ-1:0]    gnt, res_valid;
  logic [CW-1:0]      res;
  logic err, busy, mac_start, mac_a, mac_b, mac_c;
  logic mac_ready = 1'b1, mac_o = 1'b0, mac_o_valid = 1'b0, mac_end = 1'b0;

  always #5 clk = ~clk;

  mac_sched #(.NREQ(NREQ), .DW(DW), .CW(CW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .gnt(gnt), .res(res), .res_valid(res_valid), .err(err), .busy(busy),
    .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_ready(mac_ready), .mac_o(mac_o), .mac_o_valid(mac_o_valid), .mac_end(mac_end)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  int av[NREQ], bv[NREQ], cv[NREQ];
  // reference job
  bit pend = 0, jended = 0;
  int jw, ja, jb, jc, jg, jdone, jbits, jmode, ptr_m = 0;
  bit last_busy_exp = 0;
  // previous-cycle view used for arbitration
  int prev_req = 0;
  bit prev_ready = 0, prev_rst = 1, prev_free = 0;
  // behavioural mac
  int rx = -1, sa, sb, sc, val, dly, idx, nb;
  bit em = 0;
  // stimulus control and observations
  bit rand_on = 0;
  int force_mode = M_NORM;
  int gq[$];
  bit evt = 0;
  int ev_res, ev_rv, ev_err, ev_cyc, last_start_cyc = -1;
  bit just_g[NREQ];

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b, input int c);
    av[i] = a; bv[i] = b; cv[i] = c;
    a_in[i*DW +: DW] = a[DW-1:0];
    b_in[i*DW +: DW] = b[DW-1:0];
    c_in[i*CW +: CW] = c[CW-1:0];
  endtask

  function automatic int rr(input int r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (p + i) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Behavioural bit-serial mac: collects CW bits after START, answers after a random gap.
  task automatic mac_update();
    if (rst) begin
      rx = -1; em = 0;
      mac_o = 0; mac_o_valid = 0; mac_end = 0; mac_ready = 1;
      return;
    end
    mac_o = 0; mac_o_valid = 0; mac_end = 0;
    if (em) begin
      if (dly > 0) dly--;
      else begin
        mac_o_valid = 1;
        mac_o = val[idx];
        if (idx == nb - 1 && jmode != M_NOEND) begin
          mac_end = 1; jended = 1; jdone = cyc + 1;
        end
        jbits++;
        idx++;
        if (idx == nb) em = 0;
      end
    end
    if (mac_start) begin rx = 0; sa = 0; sb = 0; sc = 0; end
    if (rx >= 0) begin
      sa[rx] = mac_a; sb[rx] = mac_b; sc[rx] = mac_c;
      rx++;
      if (rx == CW) begin
        val = (sa * sb + sc) % 256;
        em = 1; dly = $urandom_range(0, 2); idx = 0;
        nb = (jmode == M_SHORT) ? 6 : CW;
        rx = -1;
      end
    end
    mac_ready = (rx < 0 && !em) ? ($urandom_range(0, 3) != 0) : 1'b0;
  endtask

  // Per-cycle comparison of every DUT output against the reference job.
  task automatic compare();
    int eg, k, e_ser, e_rv, e_err;
    bit done_now;
    if (gnt != 0) for (int i = 0; i < NREQ; i++) if (gnt[i]) gq.push_back(i);
    if (mac_start) last_start_cyc = cyc;
    if (res_valid != 0 || err) begin
      evt = 1; ev_res = res; ev_rv = res_valid; ev_err = err; ev_cyc = cyc;
    end
    if (rst) begin
      pend = 0; ptr_m = 0; last_busy_exp = 0;
      chk("reset_outs", {gnt, res, res_valid, err, busy, mac_start, mac_a, mac_b, mac_c}, 0);
      return;
    end
    eg = 0;
    if (prev_free && !prev_rst && prev_req != 0 && prev_ready) begin
      jw = rr(prev_req, ptr_m);
      eg = 1 << jw;
      pend = 1; ja = av[jw]; jb = bv[jw]; jc = cv[jw];
      jg = cyc; jdone = cyc + 1 + TMO; jbits = 0; jended = 0;
      if (force_mode >= 0) jmode = force_mode;
      else begin
        int r;
        r = $urandom_range(0, 9);
        jmode = (r < 8) ? M_NORM : (r == 8) ? M_SHORT : M_NOEND;
      end
    end
    chk("gnt", gnt, eg);
    chk("busy", busy, pend);
    last_busy_exp = pend;
    e_ser = 0;
    if (pend) begin
      k = cyc - jg - 1;
      if (k >= 0 && k < CW)
        e_ser = ((k == 0) ? 8 : 0) + ((k < DW) ? ((ja >> k) & 1) * 4 + ((jb >> k) & 1) * 2 : 0)
                + ((jc >> k) & 1);
    end
    chk("serial", {mac_start, mac_a, mac_b, mac_c}, e_ser);
    e_rv = 0; e_err = 0; done_now = 0;
    if (pend && cyc == jdone) begin
      done_now = 1;
      if (jended && jbits == CW) begin
        e_rv = 1 << jw;
        chk("res", res, (ja * jb + jc) % 256);
      end else e_err = 1;
    end
    chk("res_valid", res_valid, e_rv);
    chk("err", err, e_err);
    if (done_now) begin pend = 0; ptr_m = (jw + 1) % NREQ; end
  endtask

  task automatic step();
    prev_req = req; prev_ready = mac_ready; prev_rst = rst; prev_free = !last_busy_exp;
    @(negedge clk);
    cyc++;
    mac_update();
    #1;
    compare();
    for (int i = 0; i < NREQ; i++) begin
      just_g[i] = gnt[i];
      if (gnt[i]) req[i] = 1'b0;
    end
    if (rand_on)
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && !just_g[i] && $urandom_range(0, 3) == 0) begin
          set_ops(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
          req[i] = 1'b1;
        end
  endtask

  task automatic wait_done(input int lim, input string name);
    evt = 0;
    for (int i = 0; i < lim && !evt; i++) step();
    chk(name, int'(evt), 1);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) step();
    rst = 0;
  endtask

  initial begin
    int got;
    for (int i = 0; i < NREQ; i++) set_ops(i, 0, 0, 0);
    repeat (3) step();
    chk("reset_state", {gnt, res_valid, err, busy, mac_start}, 0);
    rst = 0;

    // single job
    gq.delete();
    force_mode = M_NORM;
    set_ops(0, 3, 5, 7); req = 2'b01;
    wait_done(100, "single_wait");
    chk("single_res", ev_res, 'h16);
    chk("single_rv", ev_rv, 1);
    chk("single_err", ev_err, 0);
    chk("single_gnt", (gq.size() == 1) ? gq[0] : -1, 0);

    // wrap-around arithmetic
    set_ops(0, 15, 15, 255); req = 2'b01;
    wait_done(100, "wrap_wait");
    chk("wrap_res", ev_res, 'hE0);
    chk("wrap_err", ev_err, 0);

    // timeout: mac never ends
    force_mode = M_NOEND;
    set_ops(1, 2, 3, 4); req = 2'b10;
    wait_done(200, "tmo_wait");
    chk("tmo_err", ev_err, 1);
    chk("tmo_rv", ev_rv, 0);
    chk("tmo_dist", ev_cyc - last_start_cyc, TMO);
    step();
    chk("tmo_busy", busy, 0);

    // short result then next request served
    force_mode = M_SHORT;
    set_ops(0, 1, 2, 3); req = 2'b01;
    wait_done(200, "short_wait");
    chk("short_err", ev_err, 1);
    chk("short_rv", ev_rv, 0);
    force_mode = M_NORM;
    set_ops(1, 6, 7, 8); req = 2'b10;
    wait_done(200, "next_wait");
    chk("next_rv", ev_rv, 2);
    chk("next_res", ev_res, 'h32);

    // contention from a fresh pointer
    do_reset();
    gq.delete();
    set_ops(0, 2, 3, 1); set_ops(1, 4, 4, 4); req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_done(200, "cont_wait");
      for (int i = 0; i < NREQ; i++) if (!req[i]) req[i] = 1'b1;
    end
    got = (gq.size() >= 4) ? gq[0]*1000 + gq[1]*100 + gq[2]*10 + gq[3] : -1;
    chk("cont_order", got, 101);

    // reset while sending bit 3
    req = 2'b00;
    do_reset();
    set_ops(0, 9, 9, 9); req = 2'b01;
    last_start_cyc = -1;
    for (int i = 0; i < 50 && last_start_cyc < 0; i++) step();
    chk("rst_send_start", int'(last_start_cyc >= 0), 1);
    repeat (3) step();
    rst = 1;
    #1;
    chk("rst_send_outs", {gnt, res_valid, err, busy, mac_start, mac_a, mac_b, mac_c}, 0);
    repeat (2) step();
    rst = 0;
    req = 2'b10;
    gq.delete();
    for (int i = 0; i < 50 && gq.size() == 0; i++) step();
    chk("rst_send_gnt", (gq.size() > 0) ? gq[0] : -1, 1);

    // random phase
    force_mode = -1;
    rand_on = 1;
    repeat (3000) step();
    rand_on = 0;
    for (int i = 0; i < 400 && (pend || req != 0); i++) step();
    chk("drain", int'(pend || req != 0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
